matrix_mult_seq: RTL and testbench
==================================

# matrix_mult_seq

Sequencer for a 4x4 single-precision matrix multiply C = A x B. It holds the A and B operand matrices, issues the 16 row/column operand pairs one at a time to the team's 4-element floating-point dot-product unit, and collects each scalar result into C. C is then available through a read port. The block is the initiator of the dot-product interface; the dot-product unit is the responder.

## Interface
- N, 4, matrix dimension; fixed, and the only supported value.
- DW, 32, element width (IEEE-754 single). Data is opaque to this block; no arithmetic is performed on it.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0 = write A, 1 = write B
- wr_addr  in  4  element index, row*4+col
- wr_data  in  DW  element value
- start  in  1  begin a multiply (level sampled each cycle)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when C is complete
- dp_valid  out  1  operand pair valid toward the dot-product unit
- dp_ready  in  1  dot-product unit accepts the pair
- dp_a0..dp_a3  out  DW  row i of A
- dp_b0..dp_b3  out  DW  column j of B
- dp_res_valid  in  1  result strobe from the dot-product unit
- dp_res  in  DW  dot-product result
- rd_addr  in  4  C element index, row*4+col
- rd_data  out  DW  C[rd_addr], registered

## Operation
- Storage: A[16], B[16], C[16] of DW bits each. All are cleared to 0 on reset.
- Operand writes:
  - Accepted only when the state is IDLE.
  - Writes while busy are dropped and leave the stored values unchanged.
- Index register k (4 bits): i = k[3:2], j = k[1:0].
- dp_a0..dp_a3 = A[i*4+0..3]; dp_b0..dp_b3 = B[0*4+j], B[1*4+j], B[2*4+j], B[3*4+j]. These drive combinationally from stored state.
- FSM states and transitions:
  - IDLE: if start, then k <= 0 and go to ISSUE.
  - ISSUE: dp_valid = 1. If dp_ready, go to WAIT. dp_valid and the operands stay stable until accepted.
  - WAIT: dp_valid = 0. If dp_res_valid, C[k] <= dp_res. Then, if k == 15, go to DONE; otherwise k <= k+1 and go to ISSUE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- Only one request is outstanding at a time. A result is never expected before its request is accepted.
- Boundary and corner conditions:
  - dp_res_valid outside WAIT is ignored.
  - dp_res_valid in the same cycle as dp_ready, while in ISSUE, is ignored.
  - start while not IDLE is ignored.
  - start held high across DONE→IDLE begins a new multiply.
  - rst_n asserted mid-operation returns the FSM to IDLE, clears A, B, C and k, and drops dp_valid immediately (asynchronously).
- Read port: rd_data <= C[rd_addr] every cycle, independent of state. A read of an element being written in the same cycle returns the old value.

## Timing
- Reset values: busy=0, done=0, dp_valid=0, rd_data=0, dp_a*/dp_b*=0 (all storage is 0).
- start sampled high in IDLE at edge t gives busy=1 and dp_valid=1 from t+1.
- Per element cost: 1 ISSUE cycle (minimum) + 1 WAIT cycle (minimum) + dot-product latency L.
  - With dp_ready held high and results arriving at the earliest legal cycle, done pulses at start edge + 33.
  - Generally: 1 + Σ(ISSUE stall + WAIT cycles) + 1.
- busy = (state != IDLE). It falls in the cycle after done.
- rd_data latency: 1 cycle.

## Structure
- Shared package `matrix_pkg`:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - localparams N=4 and DW=32;
  - the index-packing function idx(row,col).
- One sub-module is natural: `mat_regfile`, a 16xDW register array with async clear, a write port, a registered read port, and full parallel visibility for row/column muxing. Instantiate it three times (A, B, C).
- The FSM and the row/column muxes stay in the top.

## Test plan
- Identity: A = I (0x3F800000 on the diagonal, 0 elsewhere), B[n] = float(n), bench-model dot product with L=3, dp_ready=1 → C[n] == B[n] for all 16 elements; done at start+1+16*(1+4)... matches model; busy falls the cycle after done.
- All 2.0: A and B all 0x40000000 → every C = 0x41800000 (16.0); issue order of k is 0..15 and the row/column operands match at each k.
- Backpressure: dp_ready random 30% → dp_valid and operands stable while stalled; results are the same as with no backpressure.
- Illegal events: wr_en during busy, start during busy, spurious dp_res_valid in ISSUE → A, B and the final C are unaffected, and only one done pulse occurs.
- Reset mid-run: rst_n low at k=7 → dp_valid drops asynchronously; busy=0, C reads 0; a new start then completes normally.
- Back-to-back: start held high → second multiply begins the cycle after IDLE is re-entered; done pulses twice with the expected spacing.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the 4x4 matrix-multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_pkg;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int NE = N * N;

    // Index of the last element; the sequencer stops after issuing it.
    localparam logic [3:0] K_LAST = 4'(NE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Row-major element index: row*4+col.
    function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Operand/result channel between the sequencer (master) and a 4-element dot-product unit (slave).
// Latency: n/a (wiring only).
// Backpressure: dp_valid/dp_ready handshake on the operand pair; results carry no backpressure.
//
// Signals: dp_valid/dp_ready request handshake, dp_a0..3 = row of A, dp_b0..3 = column of B,
//          dp_res_valid/dp_res scalar result returned by the dot-product unit.
interface matrix_mult_seq_if;
    import matrix_pkg::*;

    logic          dp_valid;
    logic          dp_ready;
    logic [DW-1:0] dp_a0;
    logic [DW-1:0] dp_a1;
    logic [DW-1:0] dp_a2;
    logic [DW-1:0] dp_a3;
    logic [DW-1:0] dp_b0;
    logic [DW-1:0] dp_b1;
    logic [DW-1:0] dp_b2;
    logic [DW-1:0] dp_b3;
    logic          dp_res_valid;
    logic [DW-1:0] dp_res;

    modport master (
        output dp_valid, dp_a0, dp_a1, dp_a2, dp_a3, dp_b0, dp_b1, dp_b2, dp_b3,
        input  dp_ready, dp_res_valid, dp_res
    );

    modport slave (
        input  dp_valid, dp_a0, dp_a1, dp_a2, dp_a3, dp_b0, dp_b1, dp_b2, dp_b3,
        output dp_ready, dp_res_valid, dp_res
    );

endinterface

// File: rtl/mat_regfile.sv
// 16 x DW register array with async clear, one write port and full parallel visibility.
// Latency: write visible on mem the cycle after we; rdata registered, 1 cycle (old value on same-cycle write).
// Backpressure: none; every write and read is accepted.
//
// Ports: clk, rst_n (async active-low clear of all entries and rdata),
//        we/waddr/wdata write port, raddr/rdata registered read port, mem = all entries in parallel.
module mat_regfile
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [3:0]             waddr,
    input  logic [DW-1:0]          wdata,
    input  logic [3:0]             raddr,
    output logic [DW-1:0]          rdata,
    output logic [NE-1:0][DW-1:0]  mem
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequencer for C = A x B (4x4): issues the 16 row/column pairs to a dot-product unit and stores results in C.
// Latency: busy/dp_valid one cycle after start; done = start + 1 + sum(issue + wait cycles); rd_data 1 cycle.
// Backpressure: operands held stable while dp_ready is low; one request outstanding; writes dropped unless idle.
//
// Ports: clk, rst_n; wr_en/wr_sel/wr_addr/wr_data operand load (A when wr_sel=0, B when 1);
//        start/busy/done control; rd_addr/rd_data registered C read; dp = dot-product channel (master side).
module matrix_mult_seq
    import matrix_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [3:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    matrix_mult_seq_if.master dp
);

    state_t                 state;
    logic [3:0]             k;
    logic                   dp_valid_q;

    logic [NE-1:0][DW-1:0]  a_mem;
    logic [NE-1:0][DW-1:0]  b_mem;
    logic [NE-1:0][DW-1:0]  c_mem_unused;
    logic [DW-1:0]          a_rd_unused;
    logic [DW-1:0]          b_rd_unused;

    logic                   a_we;
    logic                   b_we;
    logic                   c_we;
    logic [1:0]             row;
    logic [1:0]             col;

    // Operands can only change while idle, so the pair under issue never moves mid-handshake.
    assign a_we = wr_en & ~wr_sel & (state == IDLE);
    assign b_we = wr_en &  wr_sel & (state == IDLE);

    // Results are only meaningful in WAIT; strobes in any other state are stray and ignored.
    assign c_we = (state == WAIT) & dp.dp_res_valid;

    mat_regfile u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (a_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (a_rd_unused),
        .mem   (a_mem)
    );

    mat_regfile u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (b_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (b_rd_unused),
        .mem   (b_mem)
    );

    mat_regfile u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (c_we),
        .waddr (k),
        .wdata (dp.dp_res),
        .raddr (rd_addr),
        .rdata (rd_data),
        .mem   (c_mem_unused)
    );

    // k walks C in row-major order: upper bits pick the A row, lower bits the B column.
    assign row = k[3:2];
    assign col = k[1:0];

    assign dp.dp_a0 = a_mem[idx(row, 2'd0)];
    assign dp.dp_a1 = a_mem[idx(row, 2'd1)];
    assign dp.dp_a2 = a_mem[idx(row, 2'd2)];
    assign dp.dp_a3 = a_mem[idx(row, 2'd3)];
    assign dp.dp_b0 = b_mem[idx(2'd0, col)];
    assign dp.dp_b1 = b_mem[idx(2'd1, col)];
    assign dp.dp_b2 = b_mem[idx(2'd2, col)];
    assign dp.dp_b3 = b_mem[idx(2'd3, col)];

    assign dp.dp_valid = dp_valid_q;

    // busy, done and dp_valid are registered alongside the state so they track it with no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dp_valid_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k          <= '0;
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        dp_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (dp.dp_ready) begin
                        state      <= WAIT;
                        dp_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dp.dp_res_valid) begin
                        if (k == K_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            k          <= k + 4'd1;
                            state      <= ISSUE;
                            dp_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    dp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: dot-product responder model with random stalls/latency and a C = A x B reference.
// Latency: n/a.
// Backpressure: responder drops dp_ready randomly per request when stall_pct > 0.
module tb_matrix_mult_seq;
    import matrix_pkg::*;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          wr_sel  = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start   = 1'b0;
    logic          busy;
    logic          done;
    logic [3:0]    rd_addr = '0;
    logic [DW-1:0] rd_data;

    matrix_mult_seq_if dp_if ();

    matrix_mult_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dp      (dp_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Shadow of what A and B must hold, and the expected product.
    logic [DW-1:0] ma [16];
    logic [DW-1:0] mb [16];
    logic [DW-1:0] mc [16];
    logic [DW-1:0] pin [16];

    int served     = 0;   // results delivered in the current multiply
    int exp_cycles = 0;   // sum of (issue + wait) cycles the responder has committed to
    int stall_pct  = 0;
    int resp_lat   = 0;
    bit spurious_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Single precision <-> real for normal values and zero (all bench values are small integers).
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    task automatic model_c();
        real acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0.0;
                for (int n = 0; n < 4; n++) acc += sp2r(ma[i*4+n]) * sp2r(mb[n*4+j]);
                mc[i*4+j] = r2sp(acc);
            end
        end
    endtask

    // ---------------- dot-product responder ----------------
    int phase = 0;
    int stall = 0;
    int s_tot = 0;
    int lat_left = 0;
    bit fresh = 1'b1;
    logic [DW-1:0] cap_a [4];
    logic [DW-1:0] cap_b [4];

    function automatic logic [31:0] dot4();
        real acc = 0.0;
        for (int n = 0; n < 4; n++) acc += sp2r(cap_a[n]) * sp2r(cap_b[n]);
        return r2sp(acc);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            phase = 0;
            fresh = 1'b1;
            served = 0;
            dp_if.dp_ready     = 1'b0;
            dp_if.dp_res_valid = 1'b0;
            dp_if.dp_res       = '0;
        end else begin
            if (phase == 2) phase = 0;
            if (phase == 1) begin
                dp_if.dp_ready = 1'b0;
                if (lat_left == 0) begin
                    dp_if.dp_res_valid = 1'b1;
                    dp_if.dp_res       = dot4();
                    served++;
                    phase = 2;
                end else begin
                    dp_if.dp_res_valid = 1'b0;
                    lat_left--;
                end
            end else begin
                dp_if.dp_res_valid = 1'b0;
                dp_if.dp_res       = '0;
                dp_if.dp_ready     = 1'b0;
                if (dp_if.dp_valid) begin
                    if (fresh) begin
                        stall = 0;
                        while (stall < 6 && int'($urandom_range(99)) < stall_pct) stall++;
                        s_tot = stall;
                        fresh = 1'b0;
                    end
                    if (stall > 0) begin
                        stall--;
                    end else begin
                        dp_if.dp_ready = 1'b1;
                        cap_a[0] = dp_if.dp_a0; cap_a[1] = dp_if.dp_a1;
                        cap_a[2] = dp_if.dp_a2; cap_a[3] = dp_if.dp_a3;
                        cap_b[0] = dp_if.dp_b0; cap_b[1] = dp_if.dp_b1;
                        cap_b[2] = dp_if.dp_b2; cap_b[3] = dp_if.dp_b3;
                        lat_left = resp_lat;
                        exp_cycles += 2 + s_tot + resp_lat;
                        fresh = 1'b1;
                        phase = 1;
                    end
                end
                if (spurious_en && $urandom_range(1) == 1) begin
                    dp_if.dp_res_valid = 1'b1;
                    dp_if.dp_res       = $urandom;
                end
            end
        end
    end

    // ---------------- operand compare: every cycle a pair is offered ----------------
    int cmp_r;
    int cmp_c;
    logic [255:0] cmp_e;

    always @(negedge clk) begin
        if (rst_n && dp_if.dp_valid) begin
            if (served > 15) begin
                checks++;
                errors++;
                $display("FAIL issue_count: request offered after %0d results, limit 15", served);
            end else begin
                cmp_r = served / 4;
                cmp_c = served % 4;
                cmp_e = {ma[cmp_r*4+0], ma[cmp_r*4+1], ma[cmp_r*4+2], ma[cmp_r*4+3],
                         mb[cmp_c], mb[4+cmp_c], mb[8+cmp_c], mb[12+cmp_c]};
                chk("dp_operands", {dp_if.dp_a0, dp_if.dp_a1, dp_if.dp_a2, dp_if.dp_a3,
                                    dp_if.dp_b0, dp_if.dp_b1, dp_if.dp_b2, dp_if.dp_b3}, cmp_e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load();
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                wr_en   = 1'b1;
                wr_sel  = s[0];
                wr_addr = 4'(n);
                wr_data = (s == 1) ? mb[n] : ma[n];
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic random_fill();
        for (int n = 0; n < 16; n++) begin
            ma[n] = r2sp(real'($urandom_range(9) + 1));
            mb[n] = r2sp(real'($urandom_range(9) + 1));
        end
    endtask

    task automatic read_c(input bit use_pin);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            rd_addr = 4'(n);
            @(negedge clk);
            chk("c_model", 256'(rd_data), 256'(mc[n]));
            if (use_pin) chk("c_pinned", 256'(rd_data), 256'(pin[n]));
        end
    endtask

    // Runs nruns multiplies (2 = start held high back-to-back); chaos injects writes/starts while busy.
    task automatic run(input int nruns, input bit chaos, output int first_done, output int spacing);
        int n = 0;
        int dcnt = 0;
        int dat [2];
        bit fin = 1'b0;
        dat[0] = 0;
        dat[1] = 0;
        model_c();
        served = 0;
        exp_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (!fin && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_rise", 256'(busy), 256'(1));
            if (nruns == 2) begin
                start = (dcnt < 2);
            end else if (chaos && dcnt == 0) begin
                start   = (n % 6 == 2) || done;
                wr_en   = (n % 3 == 1) || done;
                wr_sel  = 1'($urandom_range(1));
                wr_addr = 4'($urandom_range(15));
                wr_data = $urandom;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (done) begin
                if (dcnt < 2) dat[dcnt] = n;
                if (dcnt == 0) begin
                    chk("done_time", 256'(n), 256'(1 + exp_cycles));
                    if (nruns == 2) begin
                        served = 0;
                        exp_cycles = 0;
                    end
                end else if (dcnt == 1) begin
                    chk("done2_time", 256'(n), 256'(dat[0] + 2 + exp_cycles));
                end
                dcnt++;
            end
            if (nruns == 2 && dcnt >= 1 && n == dat[0] + 1) chk("b2b_idle_gap", 256'(busy), 256'(0));
            if (nruns == 2 && dcnt >= 1 && n == dat[0] + 2) chk("b2b_restart", 256'(busy), 256'(1));
            if (dcnt == nruns && n == dat[nruns-1] + 1) chk("busy_fall", 256'(busy), 256'(0));
            if (dcnt == nruns && n == dat[nruns-1] + 2) begin
                chk("stay_idle", 256'(busy), 256'(0));
                fin = 1'b1;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: %0d done pulses after %0d cycles, required %0d", dcnt, n, nruns);
        end
        chk("done_pulses", 256'(dcnt), 256'(nruns));
        start = 1'b0;
        wr_en = 1'b0;
        first_done = dat[0];
        spacing = dat[1] - dat[0];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int fd;
        int sp;
        bit hit;

        for (int n = 0; n < 16; n++) begin
            ma[n] = '0; mb[n] = '0; mc[n] = '0; pin[n] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 256'({busy, done, dp_if.dp_valid}), 256'(0));
        chk("rst_rd_data", 256'(rd_data), 256'(0));
        chk("rst_operands", {dp_if.dp_a0, dp_if.dp_a1, dp_if.dp_a2, dp_if.dp_a3,
                             dp_if.dp_b0, dp_if.dp_b1, dp_if.dp_b2, dp_if.dp_b3}, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Identity A, B[n] = float(n), latency 3, no stalls: 5 cycles per element
        for (int n = 0; n < 16; n++) begin
            ma[n] = (n / 4 == n % 4) ? 32'h3F80_0000 : 32'h0;
            mb[n] = r2sp(real'(n));
            pin[n] = mb[n];
        end
        resp_lat = 3;
        stall_pct = 0;
        load();
        run(1, 1'b0, fd, sp);
        chk("identity_done_at", 256'(fd), 256'(81));
        read_c(1'b1);

        // All 2.0, earliest results: done 33 cycles after start
        for (int n = 0; n < 16; n++) begin
            ma[n] = 32'h4000_0000;
            mb[n] = 32'h4000_0000;
            pin[n] = 32'h4180_0000;
        end
        resp_lat = 0;
        load();
        run(1, 1'b0, fd, sp);
        chk("fastest_done_at", 256'(fd), 256'(33));
        read_c(1'b1);

        // Backpressure on dp_ready
        random_fill();
        stall_pct = 30;
        resp_lat = 1;
        load();
        run(1, 1'b0, fd, sp);
        read_c(1'b0);

        // Illegal events: writes/starts while busy, stray result strobes outside WAIT
        random_fill();
        spurious_en = 1'b1;
        load();
        run(1, 1'b1, fd, sp);
        spurious_en = 1'b0;
        read_c(1'b0);

        // Reset at k=7
        random_fill();
        stall_pct = 0;
        resp_lat = 2;
        load();
        model_c();
        served = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int w = 0; w < 400 && !hit; w++) begin
            @(negedge clk);
            hit = (served == 7) && dp_if.dp_valid;
        end
        chk("reach_k7", 256'(hit), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dp_valid_async", 256'(dp_if.dp_valid), 256'(0));
        chk("rst_busy_async", 256'(busy), 256'(0));
        for (int n = 0; n < 16; n++) begin
            ma[n] = '0; mb[n] = '0; mc[n] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_c(1'b0);
        random_fill();
        load();
        run(1, 1'b0, fd, sp);
        read_c(1'b0);

        // Back-to-back with start held high
        random_fill();
        resp_lat = 0;
        load();
        run(2, 1'b0, fd, sp);
        chk("b2b_spacing", 256'(sp), 256'(34));
        read_c(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
